// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial add/subtract sequencer.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         busy;

  // Operand source / result consumer side
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  // Sequencer side
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, busy
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract sequencer: one 4-bit adder stage reused over NIBBLES
// cycles, least-significant nibble first, carry held between cycles.
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [W:0]    sum_q, sum_d;

  logic [3:0]    a_nib, b_nib;
  logic [4:0]    nib_sum;
  logic [W:0]    nib_mask, nib_val;

  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;

  // Single 4-bit adder stage on the nibble selected by idx; shifts keep the
  // select width-independent of NIBBLES.
  always_comb begin
    a_nib    = 4'(a_q >> {idx_q, 2'b00});
    b_nib    = 4'(b_q >> {idx_q, 2'b00});
    nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    nib_mask = (W+1)'(4'hF) << {idx_q, 2'b00};
    nib_val  = (W+1)'(nib_sum[3:0]) << {idx_q, 2'b00};
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~nib_mask) | nib_val;
        carry_d = nib_sum[4];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          sum_d[W] = nib_sum[4];
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl with a transaction-level model.
module tb_nibble_serial_add_ctrl;
  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.NIBBLES(N)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic straight from the result definition
  function automatic logic [W:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rs);
    int unsigned ai;
    int unsigned bi;
    ai = 32'(ra);
    bi = 32'(rb);
    if (rs) return {(ai >= bi), W'(ai - bi)};
    return (W+1)'(ai + bi);
  endfunction

  // Transaction model: busy from accept until handoff; result visible N cycles
  // after accept; low nibbles become valid one per cycle; sum holds after handoff.
  logic       m_busy = 1'b0;
  int         m_cnt  = 0;
  logic [W:0] m_exp  = '0;
  logic [W:0] m_last = '0;
  int         m_acc  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_exp  <= '0;
      m_last <= '0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_exp  <= ref_result(bus.a, bus.b, bus.sub);
        m_acc  <= m_acc + 1;
      end
    end else if (m_cnt < N) begin
      m_cnt <= m_cnt + 1;
    end else if (bus.out_ready) begin
      m_busy <= 1'b0;
      m_last <= m_exp;
    end
  end

  // Handshake counters observed at the DUT boundary
  int dut_acc  = 0;
  int dut_hand = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) dut_acc <= dut_acc + 1;
      if (bus.out_valid && bus.out_ready) dut_hand <= dut_hand + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [W:0] es;
    if (cmp_en) begin
      if (!m_busy)        es = m_last;
      else if (m_cnt == N) es = m_exp;
      else                es = m_exp & (W+1)'((64'd1 << (4 * m_cnt)) - 64'd1);
      chk("in_ready",  64'(bus.in_ready),  64'(rst_n && !m_busy));
      chk("out_valid", 64'(bus.out_valid), 64'(m_busy && (m_cnt == N)));
      chk("busy",      64'(bus.busy),      64'(m_busy));
      chk("sum",       64'(bus.sum),       64'(es));
    end
  end

  // Directed operation with literal expected result and optional backpressure
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input logic [W:0] exp, input int hold);
    int  lat;
    bit  seen;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.a         = ta;
    bus.b         = tb_v;
    bus.sub       = ts;
    bus.out_ready = (hold == 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("accept_ready", 64'(seen), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = ~ta;
    bus.b        = W'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < int'(N) + 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(N));
    chk("result",  64'(bus.sum), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.sub      = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_sum",       64'(bus.sum),       64'(exp));
      chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("handoff_drop",  64'(bus.out_valid), 64'd0);
    chk("idle_in_ready", 64'(bus.in_ready),  64'd1);
    chk("sum_kept",      64'(bus.sum),       64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0, hand0, macc0, cyc;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    cmp_en        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_sum",       64'(bus.sum),       64'd0);
    rst_n = 1'b1;

    do_op(16'h000B, 16'h0003, 1'b0, 17'h0000E, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 0);
    do_op(16'h0005, 16'h0007, 1'b1, 17'h0FFFE, 0);
    do_op(16'h1234, 16'h0234, 1'b1, 17'h11000, 0);
    do_op(16'h00FF, 16'h0001, 1'b0, 17'h00100, 10);

    // Asynchronous reset during the second RUN cycle
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'hFFFF;
    bus.b         = 16'hFFFF;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy",      64'(bus.busy),      64'd0);
    chk("abort_sum",       64'(bus.sum),       64'd0);
    chk("abort_in_ready",  64'(bus.in_ready),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op(16'h0001, 16'h0001, 1'b0, 17'h00002, 0);

    // Random back-to-back stream with in_valid held high
    acc0  = dut_acc;
    hand0 = dut_hand;
    macc0 = m_acc;
    cyc   = 0;
    bus.in_valid = 1'b1;
    while ((m_acc - macc0) < 1000 && cyc < 30000) begin
      @(posedge clk); #1;
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.sub       = 1'($urandom);
      bus.out_ready = 1'($urandom);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (N + 4) @(posedge clk);
    #1;
    chk("stream_ops_done", 64'((m_acc - macc0) >= 1000), 64'd1);
    chk("accepts_eq_handoffs", 64'(dut_hand - hand0), 64'(dut_acc - acc0));
    chk("accepts_eq_model",    64'(dut_acc - acc0),   64'(m_acc - macc0));

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs wide add/subtract by time-multiplexing a single 4-bit full-adder stage (the existing half/full adder cells) over NIBBLES cycles, least-significant nibble first.
- Carry is held in a register between cycles.
- Operands enter and results leave through valid/ready handshakes.
- Sits between operand sources and result consumers where a full-width ripple adder is too large.

Parameters:
- NIBBLES, 4, operand width in 4-bit nibbles (operand width W = 4*NIBBLES); legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- sub  input  1  0 = A+B, 1 = A-B (two's complement)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W+1  result; bit W = carry-out (for sub: 1 = no borrow, A>=B unsigned)
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values (async, while rst_n = 0):
  - state = IDLE; nibble index, carry, operand and sum registers = 0.
  - out_valid = 0, busy = 0.
  - in_ready forced 0 while rst_n = 0.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - RUN: in_ready = 0, out_valid = 0, busy = 1.
  - DONE: in_ready = 0, out_valid = 1, busy = 1.
- Accept: in IDLE, when in_valid && in_ready at a clock edge:
  - latch A_reg = a.
  - latch B_reg = sub ? ~b : b.
  - carry = sub.
  - idx = 0, clear sum register, go to RUN.
- RUN, each cycle:
  - {c, s} = A_reg[4*idx+3:4*idx] + B_reg[4*idx+3:4*idx] + carry (4-bit add, 5-bit result).
  - sum[4*idx+3:4*idx] <= s, carry <= c, idx <= idx+1.
  - On the edge processing idx = NIBBLES-1: also write sum[W] <= c and go to DONE.
- Latency: out_valid rises exactly NIBBLES cycles after the accept edge.
- DONE:
  - sum and out_valid held stable until out_ready = 1 at an edge.
  - Then go to IDLE; out_valid drops the next cycle.
  - sum keeps its last value until the next accept.
- Throughput: one operation per NIBBLES+2 cycles minimum. The IDLE cycle after DONE is mandatory; no accept in the same cycle as result handoff.
- Input hold and timing:
  - in_valid/a/b/sub are ignored outside IDLE; only the values at the accept edge matter.
  - in_valid while busy is not an error; it is held off by in_ready = 0.
  - out_ready outside DONE is ignored.
- Arithmetic:
  - Unsigned modulo 2^(W+1) for add.
  - For sub, sum[W-1:0] = (A-B) mod 2^W and sum[W] = NOT borrow.
  - No overflow/sign flags.
- NIBBLES = 1: RUN lasts one cycle; out_valid one cycle after accept.
- Reset mid-operation (RUN or DONE): immediate abort to the reset values; partial result discarded, no out_valid pulse.

Test Plan (NIBBLES = 4):
1. a=0x000B, b=0x0003, sub=0, out_ready=1 -> out_valid 4 cycles after accept, sum=0x0000E, then in_ready=1 after one IDLE cycle.
2. a=0xFFFF, b=0x0001, sub=0 -> carry ripples through all 4 nibble cycles, sum=0x10000.
3. Subtract cases:
   - a=0x0005, b=0x0007, sub=1 -> sum=0x0FFFE (bit16=0, borrow).
   - a=0x1234, b=0x0234, sub=1 -> sum=0x11000.
4. Backpressure: op 0x00FF+0x0001 with out_ready=0 for 10 cycles -> out_valid stays 1, sum stays 0x00100 stable, in_ready=0 throughout, a/b toggled during wait have no effect; out_ready=1 -> single handoff.
5. Assert rst_n=0 asynchronously (mid-cycle) during the second RUN cycle of 0xFFFF+0xFFFF -> out_valid=0, busy=0, sum=0 immediately; after release, a new op 0x0001+0x0001 gives sum=0x00002.
6. Random back-to-back stream, in_valid held high, 1000 ops with random sub/out_ready -> every result matches the reference model; count of accepts equals count of handoffs; no accept while busy.
